// File: rtl/acc_sat.sv
// Signed saturating accumulator: sums a vector of i_len beats onto a bias,
// clamping to the signed rails after every beat, with optional ReLU on the result.
module acc_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [DATA_WIDTH-1:0] i_bias,
  input  logic                  i_relu_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_sat,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  // MSB of the return value flags a clamp; the two top bits of the widened sum
  // differ exactly when the true sum left the DATA_WIDTH signed range.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    case (s[DATA_WIDTH -: 2])
      2'b01:   sat_add = {1'b1, SAT_MAX};
      2'b10:   sat_add = {1'b1, SAT_MIN};
      default: sat_add = {1'b0, s[DATA_WIDTH-1:0]};
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v,
                                                 input logic en);
    relu = (en && v[DATA_WIDTH-1]) ? {DATA_WIDTH{1'b0}} : v;
  endfunction

  state_t                state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  relu_q;
  logic                  sat_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  valid_q;
  logic                  ready_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] acc_d;
  logic                  sat_d;
  logic [LEN_WIDTH-1:0]  cnt_d;
  logic                  beat_s;
  logic                  last_s;

  // Next accumulator value and end-of-vector detection for an accepted beat.
  always_comb begin
    {sat_d, acc_d} = sat_add(acc_q, i_data);
    cnt_d          = cnt_q + LEN_ONE;
    beat_s         = i_valid & ready_q;
    last_s         = (cnt_d == len_q);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= {DATA_WIDTH{1'b0}};
      cnt_q    <= {LEN_WIDTH{1'b0}};
      len_q    <= {LEN_WIDTH{1'b0}};
      relu_q   <= 1'b0;
      sat_q    <= 1'b0;
      result_q <= {DATA_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      acc_q   <= {DATA_WIDTH{1'b0}};
      cnt_q   <= {LEN_WIDTH{1'b0}};
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            acc_q  <= i_bias;
            len_q  <= i_len;
            relu_q <= i_relu_en;
            cnt_q  <= {LEN_WIDTH{1'b0}};
            sat_q  <= 1'b0;
            busy_q <= 1'b1;
            if (i_len == {LEN_WIDTH{1'b0}}) begin
              state_q  <= OUT;
              result_q <= relu(i_bias, i_relu_en);
              valid_q  <= 1'b1;
            end else begin
              state_q <= ACCUM;
              ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat_s) begin
            acc_q <= acc_d;
            sat_q <= sat_q | sat_d;
            cnt_q <= cnt_d;
            if (last_s) begin
              state_q  <= OUT;
              result_q <= relu(acc_d, relu_q);
              valid_q  <= 1'b1;
              ready_q  <= 1'b0;
            end
          end
        end
        OUT: begin
          if (i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_sat    = sat_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_acc_sat.sv
// Directed bench for acc_sat: expected {sat, result} pairs are queued when a
// vector starts and popped when o_valid is seen.
module tb_acc_sat;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_len = 8'd0;
  logic [15:0] i_bias = 16'd0;
  logic        i_relu_en = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = 16'd0;
  logic        i_ready = 1'b0;
  logic        o_ready, o_valid, o_sat, o_busy;
  logic [15:0] o_result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  int          beats[$];

  acc_sat #(.DATA_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .i_start(i_start), .i_len(i_len),
    .i_bias(i_bias), .i_relu_en(i_relu_en), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_sat(o_sat), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent integer model, used for the long vector.
  task automatic push_model(input int bias, input bit relu_en);
    int   acc;
    bit   sat;
    acc = bias;
    sat = 1'b0;
    foreach (beats[k]) begin
      acc = acc + beats[k];
      if (acc > 32767) begin acc = 32767; sat = 1'b1; end
      else if (acc < -32768) begin acc = -32768; sat = 1'b1; end
    end
    if (relu_en && acc < 0) acc = 0;
    exp_q.push_back({sat, 16'(acc)});
  endtask

  task automatic run_vec(input int len, input int bias, input bit relu_en,
                         input bit bubbles, input int hold);
    logic [16:0] e;
    i_start = 1'b1; i_len = 8'(len); i_bias = 16'(bias); i_relu_en = relu_en;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    for (int k = 0; k < len; k++) begin
      chk("ready_in_accum", {31'd0, o_ready}, 32'd1);
      chk("no_early_valid", {31'd0, o_valid}, 32'd0);
      i_valid = 1'b1; i_data = 16'(beats[k]);
      @(negedge clk);
      i_valid = 1'b0;
      if (bubbles && k < len - 1) begin
        i_start = 1'b1; i_len = 8'd0; i_bias = 16'h1234;
        i_data = 16'h7FFF;
        @(negedge clk);
        i_start = 1'b0;
      end
    end
    chk("valid_latency", {31'd0, o_valid}, 32'd1);
    chk("ready_low_in_out", {31'd0, o_ready}, 32'd0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      e = 17'd0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("result", {16'd0, o_result}, {16'd0, e[15:0]});
    chk("sat", {31'd0, o_sat}, {31'd0, e[16]});
    for (int h = 0; h < hold; h++) begin
      i_start = 1'b1; i_len = 8'd0; i_bias = 16'h0BAD;
      @(negedge clk);
      i_start = 1'b0;
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_result", {16'd0, o_result}, {16'd0, e[15:0]});
      chk("hold_sat", {31'd0, o_sat}, {31'd0, e[16]});
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("valid_after_xfer", {31'd0, o_valid}, 32'd0);
    chk("idle_after_xfer", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_result", {16'd0, o_result}, 32'd0);
    chk("rst_sat", {31'd0, o_sat}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic accumulate.
    beats = '{5, -3, 100};
    exp_q.push_back({1'b0, 16'd112});
    run_vec(3, 10, 1'b0, 1'b0, 0);

    // Saturate high and recover.
    beats = '{32'h0200, -32'h0100, 5};
    exp_q.push_back({1'b1, 16'h7F04});
    run_vec(3, 32'h7F00, 1'b0, 1'b0, 0);

    // Negative rail with and without relu.
    beats = '{-1000, -5};
    exp_q.push_back({1'b1, 16'h0000});
    run_vec(2, -32000, 1'b1, 1'b0, 0);
    exp_q.push_back({1'b1, 16'h8000});
    run_vec(2, -32000, 1'b0, 1'b0, 0);

    // Bubbles between beats (with ignored start pulses), backpressure in OUT.
    beats = '{1, 2, 3, 4};
    exp_q.push_back({1'b0, 16'd10});
    run_vec(4, 0, 1'b0, 1'b1, 5);

    // Zero length.
    beats.delete();
    exp_q.push_back({1'b0, 16'hFFF9});
    run_vec(0, -7, 1'b0, 1'b0, 0);

    // Abort after one saturating beat of four; the beat offered with clr is dropped.
    i_start = 1'b1; i_len = 8'd4; i_bias = 16'h7F00; i_relu_en = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b1; i_data = 16'h0200;
    @(negedge clk);
    clr = 1'b1; i_data = 16'd5;
    @(negedge clk);
    clr = 1'b0; i_valid = 1'b0;
    chk("clr_busy", {31'd0, o_busy}, 32'd0);
    chk("clr_sat", {31'd0, o_sat}, 32'd0);
    chk("clr_ready", {31'd0, o_ready}, 32'd0);
    chk("clr_valid", {31'd0, o_valid}, 32'd0);
    beats = '{3};
    exp_q.push_back({1'b0, 16'd3});
    run_vec(1, 0, 1'b0, 1'b0, 0);

    // Reset mid-vector with a concurrent beat.
    i_start = 1'b1; i_len = 8'd3; i_bias = 16'd100;
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b1; i_data = 16'd7;
    @(negedge clk);
    rst = 1'b1; i_data = 16'd50;
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd0);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_result", {16'd0, o_result}, 32'd0);
    chk("midrst_sat", {31'd0, o_sat}, 32'd0);
    beats = '{9};
    exp_q.push_back({1'b0, 16'd9});
    run_vec(1, 0, 1'b0, 1'b0, 0);

    // Maximum length: counter must reach 255 without wrapping.
    beats.delete();
    for (int k = 0; k < 255; k++) beats.push_back(k % 7 - 2);
    push_model(-40, 1'b0);
    run_vec(255, -40, 1'b0, 1'b0, 0);

    // Long vector driven into the positive rail, relu on.
    beats.delete();
    for (int k = 0; k < 20; k++) beats.push_back((k < 12) ? 4000 : -3000);
    push_model(0, 1'b1);
    run_vec(20, 0, 1'b1, 1'b1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
